// File: rtl/mem_access.sv
// Memory-access stage and MEM/WB pipeline register: req/ack data-memory handshake with timeout.
// Optional misaligned-access rejection is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        regwritem,
   input  logic        memtoregm,
   input  logic        memwritem,
   input  logic        jumplinkm,
   input  logic [31:0] aluoutm,
   input  logic [31:0] writedatam,
   input  logic [4:0]  writeregm,
   input  logic [31:0] pcplus4m,
   output logic        stallm,
   output logic        memreq,
   output logic        memwe,
   output logic [31:0] memaddr,
   output logic [31:0] memwdata,
   input  logic [31:0] memrdata,
   input  logic        memack,
   output logic        regwritew,
   output logic        memtoregw,
   output logic        jumplinkw,
   output logic [31:0] readdataw,
   output logic [31:0] aluoutw,
   output logic [31:0] pcplus4w,
   output logic [4:0]  writeregw,
   output logic        memerrw,
   output logic        misalignw
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state, statenext;
   logic [7:0]  count, countnext;
   logic        memop, misalign, timeoutnow;
   logic        reqnext, wenext;
   logic [31:0] addrnext, wdnext;
   logic        capture;
   logic [31:0] readnext;
   logic        errnext, misnext;

   assign memop = memtoregm | memwritem;

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign = (state == IDLE) & memop & (aluoutm[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   // A late ack on the final wait cycle wins over the timeout.
   assign timeoutnow = (state == WAIT) & ~memack & (count == 8'(TIMEOUT - 1));

   assign stallm = ~reset & memop & ~((state == WAIT) & memack) & ~timeoutnow & ~misalign;

   // Next-state, request and W-bundle selection; the W register defaults to a bubble.
   always_comb begin
      statenext = state;
      countnext = count;
      reqnext   = memreq;
      wenext    = memwe;
      addrnext  = memaddr;
      wdnext    = memwdata;
      capture   = 1'b0;
      readnext  = 32'd0;
      errnext   = 1'b0;
      misnext   = 1'b0;
      case (state)
         IDLE: begin
            if (misalign) begin
               misnext = 1'b1;
            end else if (memop) begin
               reqnext   = 1'b1;
               wenext    = memwritem;
               addrnext  = {aluoutm[31:2], 2'b00};
               wdnext    = writedatam;
               countnext = 8'd0;
               statenext = WAIT;
            end else begin
               capture = 1'b1;
            end
         end
         WAIT: begin
            if (memack) begin
               capture   = 1'b1;
               readnext  = memwritem ? 32'd0 : memrdata;
               reqnext   = 1'b0;
               statenext = IDLE;
            end else if (timeoutnow) begin
               reqnext   = 1'b0;
               errnext   = 1'b1;
               statenext = IDLE;
            end else begin
               countnext = count + 8'd1;
            end
         end
         default: statenext = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         count     <= 8'd0;
         memreq    <= 1'b0;
         memwe     <= 1'b0;
         memaddr   <= 32'd0;
         memwdata  <= 32'd0;
         regwritew <= 1'b0;
         memtoregw <= 1'b0;
         jumplinkw <= 1'b0;
         readdataw <= 32'd0;
         aluoutw   <= 32'd0;
         pcplus4w  <= 32'd0;
         writeregw <= 5'd0;
         memerrw   <= 1'b0;
         misalignw <= 1'b0;
      end else begin
         state     <= statenext;
         count     <= countnext;
         memreq    <= reqnext;
         memwe     <= wenext;
         memaddr   <= addrnext;
         memwdata  <= wdnext;
         regwritew <= capture & regwritem;
         memtoregw <= capture & memtoregm;
         jumplinkw <= capture & jumplinkm;
         readdataw <= readnext;
         aluoutw   <= capture ? aluoutm : 32'd0;
         pcplus4w  <= capture ? pcplus4m : 32'd0;
         writeregw <= capture ? writeregm : 5'd0;
         memerrw   <= errnext;
         misalignw <= misnext;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, reset-in-WAIT sequence, then random ops
// scored against a spec-level model of latency, timeout and memory contents.
module tb_mem_access;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        regwritem, memtoregm, memwritem, jumplinkm;
   logic [31:0] aluoutm, writedatam, pcplus4m;
   logic [4:0]  writeregm;
   logic        stallm, memreq, memwe;
   logic [31:0] memaddr, memwdata, memrdata;
   logic        memack;
   logic        regwritew, memtoregw, jumplinkw;
   logic [31:0] readdataw, aluoutw, pcplus4w;
   logic [4:0]  writeregw;
   logic        memerrw, misalignw;

   mem_access #(.TIMEOUT(T)) dut (
      .clk(clk), .reset(reset),
      .regwritem(regwritem), .memtoregm(memtoregm), .memwritem(memwritem), .jumplinkm(jumplinkm),
      .aluoutm(aluoutm), .writedatam(writedatam), .writeregm(writeregm), .pcplus4m(pcplus4m),
      .stallm(stallm), .memreq(memreq), .memwe(memwe), .memaddr(memaddr), .memwdata(memwdata),
      .memrdata(memrdata), .memack(memack),
      .regwritew(regwritew), .memtoregw(memtoregw), .jumplinkw(jumplinkw),
      .readdataw(readdataw), .aluoutw(aluoutw), .pcplus4w(pcplus4w), .writeregw(writeregw),
      .memerrw(memerrw), .misalignw(misalignw)
   );

   always #5 clk = ~clk;

   int assertCount = 0;
   int failCount   = 0;
   logic [31:0] memArray [256];
   logic [31:0] refMem   [256];

   typedef struct {
      string       name;
      logic        rw, mtr, mw, jl;
      logic [31:0] alu, wd, pc;
      logic [4:0]  wr;
      int          lat;
      int          eStall, eReq;
      logic        eRw, eMtr, eJl, eBubble, eErr, eMis, eWe;
      logic [31:0] eRead, eAddr;
   } vecT;

   vecT table_v [$];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vecT mk(string name, logic rw, logic mtr, logic mw, logic jl,
                              logic [31:0] alu, logic [31:0] wd, logic [31:0] pc, logic [4:0] wr,
                              int lat, int eStall, int eReq, logic eRw, logic eMtr, logic eJl,
                              logic eBubble, logic eErr, logic eMis, logic eWe,
                              logic [31:0] eRead, logic [31:0] eAddr);
      vecT v;
      v.name = name; v.rw = rw; v.mtr = mtr; v.mw = mw; v.jl = jl;
      v.alu = alu; v.wd = wd; v.pc = pc; v.wr = wr; v.lat = lat;
      v.eStall = eStall; v.eReq = eReq; v.eRw = eRw; v.eMtr = eMtr; v.eJl = eJl;
      v.eBubble = eBubble; v.eErr = eErr; v.eMis = eMis; v.eWe = eWe;
      v.eRead = eRead; v.eAddr = eAddr;
      return v;
   endfunction

   // Reference model: lat is the number of unanswered wait cycles before memack.
   task automatic predict(inout vecT v);
      bit memop, mis;
      int idx;
      memop = v.mtr | v.mw;
      idx   = int'(v.alu[9:2]);
`ifdef MEM_ALIGN_CHECK_EN
      mis = memop && (v.alu[1:0] != 2'b00);
`else
      mis = 1'b0;
`endif
      v.eWe = v.mw; v.eAddr = {v.alu[31:2], 2'b00};
      v.eErr = 0; v.eMis = 0; v.eBubble = 0; v.eRead = 0;
      v.eRw = v.rw; v.eMtr = v.mtr; v.eJl = v.jl;
      if (!memop) begin
         v.eStall = 0; v.eReq = 0;
      end else if (mis) begin
         v.eStall = 0; v.eReq = 0; v.eMis = 1; v.eBubble = 1;
      end else if (v.lat <= T - 1) begin
         v.eStall = v.lat + 1; v.eReq = v.lat + 1;
         if (v.mw) refMem[idx] = v.wd;
         else      v.eRead = refMem[idx];
      end else begin
         v.eStall = T; v.eReq = T; v.eErr = 1; v.eBubble = 1;
      end
      if (v.eBubble) begin
         v.eRw = 0; v.eMtr = 0; v.eJl = 0;
      end
   endtask

   // Presents one op, acts as the data memory, and checks the retired W bundle.
   task automatic applyStimulus(input vecT v);
      int stalls = 0, reqs = 0, w = 0, cyc = 0;
      bit done = 0;
      regwritem = v.rw; memtoregm = v.mtr; memwritem = v.mw; jumplinkm = v.jl;
      aluoutm = v.alu; writedatam = v.wd; pcplus4m = v.pc; writeregm = v.wr;
      while (!done && cyc < 50) begin
         if (memreq) begin
            checkOutput({v.name, " memaddr"}, memaddr, v.eAddr);
            checkOutput({v.name, " memwe"}, 32'(memwe), 32'(v.eWe));
            checkOutput({v.name, " memwdata"}, memwdata, v.wd);
            memack   = (w == v.lat);
            memrdata = memArray[memaddr[9:2]];
            if (memack && memwe) memArray[memaddr[9:2]] = memwdata;
            reqs++; w++;
         end else begin
            memack   = 1'($urandom);
            memrdata = $urandom;
         end
         @(negedge clk);
         if (stallm) stalls++;
         else done = 1;
         @(posedge clk);
         #1;
         cyc++;
      end
      memack = 1'b0;
      if (!done) begin
         assertCount++; failCount++;
         $display("[TB] FAIL %s completion: stallm still high after %0d cycles, required to drop", v.name, cyc);
      end
      checkOutput({v.name, " stall cycles"}, 32'(stalls), 32'(v.eStall));
      checkOutput({v.name, " memreq cycles"}, 32'(reqs), 32'(v.eReq));
      checkOutput({v.name, " memreq after"}, 32'(memreq), 32'd0);
      checkOutput({v.name, " regwritew"}, 32'(regwritew), 32'(v.eRw));
      checkOutput({v.name, " memtoregw"}, 32'(memtoregw), 32'(v.eMtr));
      checkOutput({v.name, " jumplinkw"}, 32'(jumplinkw), 32'(v.eJl));
      checkOutput({v.name, " readdataw"}, readdataw, v.eRead);
      checkOutput({v.name, " aluoutw"}, aluoutw, v.eBubble ? 32'd0 : v.alu);
      checkOutput({v.name, " pcplus4w"}, pcplus4w, v.eBubble ? 32'd0 : v.pc);
      checkOutput({v.name, " writeregw"}, 32'(writeregw), v.eBubble ? 32'd0 : 32'(v.wr));
      checkOutput({v.name, " memerrw"}, 32'(memerrw), 32'(v.eErr));
      checkOutput({v.name, " misalignw"}, 32'(misalignw), 32'(v.eMis));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vecT v;
      for (int i = 0; i < 256; i++) memArray[i] = $urandom;
      memArray[64] = 32'hDEADBEEF;

      //                 name        rw mtr mw jl alu           wd            pc         wr lat st rq eRw eMtr eJl bub err mis we eRead         eAddr
      table_v.push_back(mk("alu",     1, 0, 0, 0, 32'h1234,     32'h0,        32'h40,    5,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h1234));
      table_v.push_back(mk("ld100",   1, 1, 0, 0, 32'h100,      32'h0,        32'h44,    8,  2, 3, 3, 1, 1, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h100));
      table_v.push_back(mk("st204",   0, 0, 1, 0, 32'h204,      32'hCAFEF00D, 32'h48,    0,  0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h204));
      table_v.push_back(mk("ld204",   1, 1, 0, 0, 32'h204,      32'h0,        32'h4C,    9,  1, 2, 2, 1, 1, 0, 0, 0, 0, 0, 32'hCAFEF00D, 32'h204));
      table_v.push_back(mk("timeout", 1, 1, 0, 0, 32'h100,      32'h0,        32'h50,   10, 99, 4, 4, 0, 0, 0, 1, 1, 0, 0, 32'h0,        32'h100));
      table_v.push_back(mk("jal",     1, 0, 0, 1, 32'h55,       32'h0,        32'h80,   31,  0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 32'h0,        32'h55));
      table_v.push_back(mk("ackedge", 1, 1, 0, 0, 32'h100,      32'h0,        32'h84,   11,  3, 4, 4, 1, 1, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h100));
`ifdef MEM_ALIGN_CHECK_EN
      table_v.push_back(mk("ld102",   1, 1, 0, 0, 32'h102,      32'h0,        32'h88,   12,  0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h0,        32'h100));
`else
      table_v.push_back(mk("ld102",   1, 1, 0, 0, 32'h102,      32'h0,        32'h88,   12,  0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h100));
`endif
      table_v.push_back(mk("ldst",    0, 1, 1, 0, 32'h300,      32'h11111111, 32'h8C,   13,  0, 1, 1, 0, 1, 0, 0, 0, 0, 1, 32'h0,        32'h300));
      table_v.push_back(mk("alu2",    1, 0, 0, 0, 32'hFFFF0000, 32'h0,        32'h90,    3,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'hFFFF0000));

      reset = 1'b1;
      regwritem = 0; memtoregm = 0; memwritem = 0; jumplinkm = 0;
      aluoutm = 0; writedatam = 0; pcplus4m = 0; writeregm = 0;
      memack = 0; memrdata = 0;
      #12;
      checkOutput("reset memreq", 32'(memreq), 32'd0);
      checkOutput("reset stallm", 32'(stallm), 32'd0);
      checkOutput("reset regwritew", 32'(regwritew), 32'd0);
      checkOutput("reset aluoutw", aluoutw, 32'd0);
      checkOutput("reset memerrw", 32'(memerrw), 32'd0);
      checkOutput("reset misalignw", 32'(misalignw), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      foreach (table_v[i]) applyStimulus(table_v[i]);

      // Reset while a load waits: memreq must drop with no clock edge.
      memtoregm = 1; regwritem = 1; memwritem = 0; jumplinkm = 0; aluoutm = 32'h100;
      @(posedge clk);
      #1;
      checkOutput("rstwait memreq before", 32'(memreq), 32'd1);
      #1 reset = 1'b1;
      #1;
      checkOutput("rstwait memreq", 32'(memreq), 32'd0);
      checkOutput("rstwait stallm", 32'(stallm), 32'd0);
      checkOutput("rstwait memaddr", memaddr, 32'd0);
      checkOutput("rstwait memwe", 32'(memwe), 32'd0);
      checkOutput("rstwait regwritew", 32'(regwritew), 32'd0);
      checkOutput("rstwait readdataw", readdataw, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      applyStimulus(mk("postrst", 1, 1, 0, 0, 32'h100, 32'h0, 32'hA0, 7, 1, 2, 2, 1, 1, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h100));

      for (int i = 0; i < 256; i++) begin
         memArray[i] = $urandom;
         refMem[i]   = memArray[i];
      end
      for (int n = 0; n < 60; n++) begin
         int k;
         k = $urandom_range(0, 3);
         v.name = $sformatf("rnd%0d", n);
         v.rw = 1'($urandom); v.jl = 0; v.mtr = 0; v.mw = 0;
         v.wd = $urandom; v.pc = $urandom; v.wr = 5'($urandom);
         v.alu = {$urandom} & 32'hFFFF_FFFC;
         if ($urandom_range(0, 3) == 0) v.alu[1:0] = 2'($urandom);
         v.lat = $urandom_range(0, 5);
         case (k)
            0: v.jl = 1'($urandom);
            1: v.mtr = 1;
            2: v.mw = 1;
            default: begin v.mtr = 1; v.mw = 1; end
         endcase
         predict(v);
         applyStimulus(v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
